// File: rtl/serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sched
// Purpose  : Two-requester scheduler around one shared bit-serial full adder.
//            A round-robin arbiter grants one requester in IDLE. The granted
//            operands are then added LSB first, one bit per clock, for WIDTH
//            clocks. The result is presented with a one-cycle done pulse.
// Ports    : clk, rst (async, active-high)
//            req0/a0/b0/cin0, req1/a1/b1/cin1 : requester inputs
//            gnt0, gnt1 : grant pulses; operands captured in that cycle
//            busy       : operation in progress (SHIFT or DONE)
//            done       : one-cycle pulse; sum/cout/owner valid
//            owner, sum, cout : registered result, held until next done
// Options  : `define SERIAL_ADD_SCHED_SUB_EN adds sub0/sub1 inputs
//            (sub=1 computes a - b; cout=1 means no borrow)
// Revision : 1.0  initial release
// ============================================================================
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
`ifdef SERIAL_ADD_SCHED_SUB_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    // r_a doubles as the result accumulator: each sum bit enters at the MSB
    // while the consumed operand bit leaves at the LSB.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_cur;   // requester being served
    logic               r_last;  // requester served last (round-robin)
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_owner;

    logic               w_any;
    logic               w_pick;
    logic               w_grant;
    logic               w_last;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_shift;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;
    logic               w_cin_sel;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the one not served last.
    // ------------------------------------------------------------------
    assign w_any  = req0 | req1;
    assign w_pick = (req0 & req1) ? ~r_last : req1;

    assign w_a_sel   = w_pick ? a1   : a0;
    assign w_b_sel   = w_pick ? b1   : b0;
    assign w_cin_sel = w_pick ? cin1 : cin0;

`ifdef SERIAL_ADD_SCHED_SUB_EN
    logic w_sub;
    assign w_sub    = w_pick ? sub1 : sub0;
    // a - b == a + ~b + 1; the requester's own carry-in is ignored.
    assign w_b_in   = w_sub ? ~w_b_sel : w_b_sel;
    assign w_cin_in = w_sub | w_cin_sel;
`else
    assign w_b_in   = w_b_sel;
    assign w_cin_in = w_cin_sel;
`endif

    // ------------------------------------------------------------------
    // Shared 1-bit full-adder cell
    // ------------------------------------------------------------------
    assign w_s     = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_shift = {w_s, r_a[WIDTH-1:1]};
    assign w_last  = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_any)  w_state_nxt = c_st_shift;
            c_st_shift: if (w_last) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Grants are combinational so the capture happens on the
    // edge that closes the grant cycle; they are masked while in reset.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_idle: begin
                gnt0 = ~rst & w_any & ~w_pick;
                gnt1 = ~rst & w_any &  w_pick;
            end
            c_st_shift: busy = 1'b1;
            c_st_done: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_grant = gnt0 | gnt1;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cur   <= 1'b0;
            r_last  <= 1'b1;  // requester 0 wins the first tie
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_owner <= 1'b0;
        end else if (w_grant) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
            r_cur   <= w_pick;
            r_last  <= w_pick;
        end else if (r_state == c_st_shift) begin
            r_a     <= w_shift;
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c;
            if (w_last) begin
                r_cnt   <= '0;
                r_sum   <= w_shift;
                r_cout  <= w_c;
                r_owner <= r_cur;
            end else begin
                r_cnt   <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign sum   = r_sum;
    assign cout  = r_cout;
    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sched
// Purpose  : Scoreboard bench for serial_add_sched (WIDTH=8). Stimulus pushes
//            expected results with their due cycle; a monitor pops and
//            compares on every done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_sched;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, cin0, cin1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, busy, done, owner, cout;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_SCHED_SUB_EN
    logic             sub0 = 1'b0;
    logic             sub1 = 1'b0;
`endif

    serial_add_sched #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .cin0  (cin0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .cin1  (cin1),
`ifdef SERIAL_ADD_SCHED_SUB_EN
        .sub0  (sub0),
        .sub1  (sub1),
`endif
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .owner (owner),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             own;
        logic [WIDTH-1:0] s;
        logic             c;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("done_sum",   sum,   e.s);
                check("done_cout",  cout,  e.c);
                check("done_owner", owner, e.own);
                check("done_cycle", cyc,   e.due);
            end
        end
    end

    // Request one operation from an idle DUT; grant is expected immediately.
    task automatic issue(input logic which, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic [WIDTH-1:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        if (which == 1'b0) begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = ci;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
        end
        #1;
        check("gnt0", gnt0, which == 1'b0);
        check("gnt1", gnt1, which == 1'b1);
        e.own = which;
        e.s   = es;
        e.c   = ec;
        e.due = cyc + WIDTH + 1;
        sb.push_back(e);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        // Operands are only sampled in the grant cycle.
        a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); cin0 = 1'($urandom);
        a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); cin1 = 1'($urandom);
        #1;
        check("busy_shift", busy, 1'b1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   t0;
        int   budget;
        logic exp_id;

        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; cin0 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        req0 = 1'b1;
        #1;
        // Reset state, with a request pending that must not be granted.
        check("rst_gnt0",  gnt0,  1'b0);
        check("rst_gnt1",  gnt1,  1'b0);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_sum",   sum,   8'h00);
        check("rst_cout",  cout,  1'b0);
        check("rst_owner", owner, 1'b0);

        // Both requesters held from reset release: grants alternate 0,1,0.
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h02; cin0 = 1'b0;
        req1 = 1'b1; a1 = 8'h10; b1 = 8'h20; cin1 = 1'b1;
        rst  = 1'b0;
        t0   = cyc;
        for (int k = 0; k < 3; k++) begin
            budget = 15;
            if (k != 0) @(negedge clk);
            #1;
            while (!(gnt0 || gnt1) && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
            exp_id = (k == 1);
            check("tie_gnt", {gnt0, gnt1}, exp_id ? 2'b01 : 2'b10);
            check("tie_gnt_cycle", cyc, t0 + (WIDTH + 2) * k);
            e.own = exp_id;
            e.s   = exp_id ? 8'h31 : 8'h03;
            e.c   = 1'b0;
            e.due = t0 + (WIDTH + 2) * k + WIDTH + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_drain();

        // Single requesters, assorted operands.
        issue(1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        wait_drain();
        issue(1'b1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
        wait_drain();
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        wait_drain();
        issue(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        wait_drain();
        issue(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        wait_drain();

        // A request arriving mid-operation is ignored.
        issue(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        @(negedge clk);
        req1 = 1'b1; a1 = 8'h77; b1 = 8'h11; cin1 = 1'b0;
        #1;
        check("shift_gnt1", gnt1, 1'b0);
        @(negedge clk);
        req1 = 1'b0;
        wait_drain();

`ifdef SERIAL_ADD_SCHED_SUB_EN
        sub0 = 1'b1;
        issue(1'b0, 8'h10, 8'h03, 1'b0, 8'h0D, 1'b1);
        wait_drain();
        issue(1'b0, 8'h03, 8'h10, 1'b1, 8'hF3, 1'b0);
        wait_drain();
        sub0 = 1'b0;
`endif

        // Abort by reset in the 4th SHIFT cycle; requester 0 is served last.
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h5A; b0 = 8'h33; cin0 = 1'b0;
        #1;
        check("abort_gnt0", gnt0, 1'b1);
        @(negedge clk);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_sum",  sum,  8'h00);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h5A; b0 = 8'h33; cin0 = 1'b0;
        req1 = 1'b1; a1 = 8'h01; b1 = 8'h01; cin1 = 1'b0;
        rst  = 1'b0;
        #1;
        check("post_rst_gnt", {gnt0, gnt1}, 2'b10);
        e.own = 1'b0;
        e.s   = 8'h8D;
        e.c   = 1'b0;
        e.due = cyc + WIDTH + 1;
        sb.push_back(e);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
